// File: rtl/dcache_pkg.sv
// Shared types and constants for the 2-way, 8-set, 32-byte-line dcache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_CMP    = 2'd0,
    S_WB     = 2'd1,
    S_FILL   = 2'd2,
    S_SETTLE = 2'd3
  } dcache_state_t;

  localparam int WAYS       = 2;
  localparam int LINE_BYTES = 32;
  localparam logic [LINE_BYTES-1:0] FULL_MASK = 32'hFFFF_FFFF;

  // Way index from the one-hot hit vector; a (illegal) double hit resolves to way 0.
  function automatic logic hit_way(input logic [WAYS-1:0] hit);
    return (hit == 2'b10);
  endfunction

endpackage

// File: rtl/dcache_control_if.sv
// Controller-facing bundle: CPU request/response, pmem handshake and datapath strobes/status.
interface dcache_control_if;
  import dcache_pkg::*;

  logic                  mem_read;
  logic                  mem_write;
  logic [LINE_BYTES-1:0] mem_byte_enable256;
  logic                  mem_resp;

  logic                  pmem_resp;
  logic                  pmem_read;
  logic                  pmem_write;

  logic [WAYS-1:0]       hit_datapath;
  logic                  lru_output;
  logic [WAYS-1:0]       valid_out;
  logic [WAYS-1:0]       dirty_out;

  logic                  mem_enable_sel;
  logic [LINE_BYTES-1:0] write_enable_0;
  logic [LINE_BYTES-1:0] write_enable_1;
  logic                  load_lru;
  logic                  set_lru;
  logic [WAYS-1:0]       load_valid;
  logic [WAYS-1:0]       set_valid;
  logic [WAYS-1:0]       load_dirty;
  logic [WAYS-1:0]       set_dirty;
  logic [WAYS-1:0]       load_tag;
  logic                  data_array_select;

  modport master (
    input  mem_read, mem_write, mem_byte_enable256, pmem_resp,
           hit_datapath, lru_output, valid_out, dirty_out,
    output mem_resp, pmem_read, pmem_write, mem_enable_sel,
           write_enable_0, write_enable_1, load_lru, set_lru,
           load_valid, set_valid, load_dirty, set_dirty, load_tag,
           data_array_select
  );

  modport slave (
    output mem_read, mem_write, mem_byte_enable256, pmem_resp,
           hit_datapath, lru_output, valid_out, dirty_out,
    input  mem_resp, pmem_read, pmem_write, mem_enable_sel,
           write_enable_0, write_enable_1, load_lru, set_lru,
           load_valid, set_valid, load_dirty, set_dirty, load_tag,
           data_array_select
  );

endinterface

// File: rtl/dcache_perf_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module dcache_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_control.sv
// Sequencing FSM for the 2-way dcache: hit handling, write-back, line fill, perf counters.
// state    | meaning
// S_CMP    | compare tags; hits complete here, misses pick victim v
// S_WB     | write dirty victim line back to pmem
// S_FILL   | read new line from pmem into way v
// S_SETTLE | one cycle for array outputs to reflect the fill
module dcache_control
  import dcache_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  dcache_control_if.master bus,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o
);

  localparam logic [1:0] ST_CMP    = S_CMP;
  localparam logic [1:0] ST_WB     = S_WB;
  localparam logic [1:0] ST_FILL   = S_FILL;
  localparam logic [1:0] ST_SETTLE = S_SETTLE;

  if (NUM_WAYS != WAYS) begin : g_ways_chk
    $error("dcache_control supports exactly 2 ways");
  end

  logic [1:0]            state_q, state_d;
  logic                  v_q, v_d;
  logic                  req, any_hit, hit_w;
  logic                  hit_inc, miss_inc, wb_inc;
  logic                  resp, pmem_rd, pmem_wr, sel, ld_lru, st_lru, das;
  logic [LINE_BYTES-1:0] we0, we1;
  logic [WAYS-1:0]       ld_valid, st_valid, ld_dirty, st_dirty, ld_tag;

  always_comb begin
    req      = bus.mem_read | bus.mem_write;
    any_hit  = |bus.hit_datapath;
    hit_w    = hit_way(bus.hit_datapath);
    state_d  = state_q;
    v_d      = v_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    wb_inc   = 1'b0;
    resp     = 1'b0;
    pmem_rd  = 1'b0;
    pmem_wr  = 1'b0;
    sel      = 1'b0;
    ld_lru   = 1'b0;
    st_lru   = 1'b0;
    das      = 1'b0;
    we0      = '0;
    we1      = '0;
    ld_valid = '0;
    st_valid = '0;
    ld_dirty = '0;
    st_dirty = '0;
    ld_tag   = '0;

    case (state_q)
      ST_CMP: begin
        if (req) begin
          if (any_hit) begin
            resp    = 1'b1;
            ld_lru  = 1'b1;
            st_lru  = ~hit_w;
            das     = hit_w;
            hit_inc = 1'b1;
            if (bus.mem_write) begin
              ld_dirty[hit_w] = 1'b1;
              st_dirty[hit_w] = 1'b1;
              if (hit_w) we1 = bus.mem_byte_enable256;
              else       we0 = bus.mem_byte_enable256;
            end
          end else begin
            // Victim is latched here so a wandering lru_output cannot retarget the fill.
            miss_inc = 1'b1;
            v_d      = bus.lru_output;
            das      = bus.lru_output;
            state_d  = (bus.valid_out[bus.lru_output] & bus.dirty_out[bus.lru_output])
                       ? ST_WB : ST_FILL;
          end
        end
      end
      ST_WB: begin
        pmem_wr = 1'b1;
        das     = v_q;
        if (bus.pmem_resp) begin
          wb_inc        = 1'b1;
          ld_dirty[v_q] = 1'b1;
          st_dirty[v_q] = 1'b0;
          state_d       = ST_FILL;
        end
      end
      ST_FILL: begin
        pmem_rd = 1'b1;
        sel     = 1'b1;
        das     = v_q;
        if (bus.pmem_resp) begin
          if (v_q) we1 = FULL_MASK;
          else     we0 = FULL_MASK;
          ld_tag[v_q]   = 1'b1;
          ld_valid[v_q] = 1'b1;
          st_valid[v_q] = 1'b1;
          ld_dirty[v_q] = 1'b1;
          st_dirty[v_q] = 1'b0;
          state_d       = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        das     = v_q;
        state_d = ST_CMP;
      end
      default: state_d = ST_CMP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CMP;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
    end
  end

  assign bus.mem_resp          = resp;
  assign bus.pmem_read         = pmem_rd;
  assign bus.pmem_write        = pmem_wr;
  assign bus.mem_enable_sel    = sel;
  assign bus.write_enable_0    = we0;
  assign bus.write_enable_1    = we1;
  assign bus.load_lru          = ld_lru;
  assign bus.set_lru           = st_lru;
  assign bus.load_valid        = ld_valid;
  assign bus.set_valid         = st_valid;
  assign bus.load_dirty        = ld_dirty;
  assign bus.set_dirty         = st_dirty;
  assign bus.load_tag          = ld_tag;
  assign bus.data_array_select = das;

  dcache_perf_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(hit_inc), .cnt_o(hit_cnt_o)
  );

  dcache_perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(miss_inc), .cnt_o(miss_cnt_o)
  );

  dcache_perf_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(wb_inc), .cnt_o(wb_cnt_o)
  );

  a_no_double_hit: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == ST_CMP) && req && (bus.hit_datapath == 2'b11)))
    else $error("dcache_control: both ways hit");

  a_pmem_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(pmem_rd && pmem_wr))
    else $error("dcache_control: pmem read and write together");

endmodule
